// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall and forwarding-select generation for the 5-stage MIPS pipeline.
// The shadow pipeline tracks the producers in flight:
//   *_p0 = E stage, *_p1 = M stage, *_p2 = W stage.
// Forwarding select codes:
//   D-stage sels: 00 GRF, 01 from E, 10 from M.
//   E-stage sels: 00 D/E value, 01 from M, 10 from W.
module hazard_ctrl #(
   parameter int REG_W = 5,
   parameter int TN_W  = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] rs_D,
   input  logic [REG_W-1:0] rt_D,
   input  logic [TN_W-1:0]  tuse_rs_D,
   input  logic [TN_W-1:0]  tuse_rt_D,
   input  logic [REG_W-1:0] a3_D,
   input  logic [TN_W-1:0]  tnew_D,
   input  logic             md_D,
   input  logic             md_start_D,
   input  logic             md_busy,
   output logic             stall,
   output logic [1:0]       fwd_rs_D,
   output logic [1:0]       fwd_rt_D,
   output logic [1:0]       fwd_rs_E,
   output logic [1:0]       fwd_rt_E
);

   // E stage shadow
   logic [REG_W-1:0] a3_p0;
   logic [TN_W-1:0]  tnew_p0;
   logic [REG_W-1:0] rs_p0;
   logic [REG_W-1:0] rt_p0;
   logic             mdStart_p0;
   // M stage shadow
   logic [REG_W-1:0] a3_p1;
   logic [TN_W-1:0]  tnew_p1;
   // W stage shadow (its result is always ready, so no tnew is kept)
   logic [REG_W-1:0] a3_p2;

   // Register 0 is hard-wired, so it never creates a dependency.
   function automatic logic hit(input logic [REG_W-1:0] src,
                                input logic [REG_W-1:0] dst);
      return (src != '0) && (src == dst);
   endfunction

   // Result latency counts down one per stage and holds at zero.
   function automatic logic [TN_W-1:0] decTnew(input logic [TN_W-1:0] t);
      return (t == '0) ? '0 : t - TN_W'(1);
   endfunction

   // A producer that is not ready yet blocks forwarding from an older stage
   // (sel 00); the stall logic keeps that case from being consumed.
   function automatic logic [1:0] selD(input logic [REG_W-1:0] src,
                                       input logic [REG_W-1:0] a3E,
                                       input logic [TN_W-1:0]  tnE,
                                       input logic [REG_W-1:0] a3M,
                                       input logic [TN_W-1:0]  tnM);
      if (hit(src, a3E))
         return (tnE == '0) ? 2'b01 : 2'b00;
      else if (hit(src, a3M))
         return (tnM == '0) ? 2'b10 : 2'b00;
      else
         return 2'b00;
   endfunction

   function automatic logic [1:0] selE(input logic [REG_W-1:0] src,
                                       input logic [REG_W-1:0] a3M,
                                       input logic [TN_W-1:0]  tnM,
                                       input logic [REG_W-1:0] a3W);
      if (hit(src, a3M))
         return (tnM == '0) ? 2'b01 : 2'b00;
      else if (hit(src, a3W))
         return 2'b10;
      else
         return 2'b00;
   endfunction

   // Stall when a D source is produced too late, or the MDU is occupied.
   always_comb begin
      stall = 1'b0;
      if (hit(rs_D, a3_p0) && (tnew_p0 > tuse_rs_D)) stall = 1'b1;
      if (hit(rs_D, a3_p1) && (tnew_p1 > tuse_rs_D)) stall = 1'b1;
      if (hit(rt_D, a3_p0) && (tnew_p0 > tuse_rt_D)) stall = 1'b1;
      if (hit(rt_D, a3_p1) && (tnew_p1 > tuse_rt_D)) stall = 1'b1;
      if (md_D && (md_busy || mdStart_p0))           stall = 1'b1;
   end

   // Forwarding selects: youngest ready producer wins.
   always_comb begin
      fwd_rs_D = selD(rs_D, a3_p0, tnew_p0, a3_p1, tnew_p1);
      fwd_rt_D = selD(rt_D, a3_p0, tnew_p0, a3_p1, tnew_p1);
      fwd_rs_E = selE(rs_p0, a3_p1, tnew_p1, a3_p2);
      fwd_rt_E = selE(rt_p0, a3_p1, tnew_p1, a3_p2);
   end

   // Shadow pipeline advance; a stall injects a bubble into E.
   always_ff @(posedge clk) begin
      if (reset) begin
         a3_p0      <= '0;
         tnew_p0    <= '0;
         rs_p0      <= '0;
         rt_p0      <= '0;
         mdStart_p0 <= 1'b0;
         a3_p1      <= '0;
         tnew_p1    <= '0;
         a3_p2      <= '0;
      end else begin
         // M -> W
         a3_p2   <= a3_p1;
         // E -> M
         a3_p1   <= a3_p0;
         tnew_p1 <= decTnew(tnew_p0);
         // D -> E
         if (stall) begin
            a3_p0      <= '0;
            tnew_p0    <= '0;
            rs_p0      <= '0;
            rt_p0      <= '0;
            mdStart_p0 <= 1'b0;
         end else begin
            a3_p0      <= a3_D;
            tnew_p0    <= tnew_D;
            rs_p0      <= rs_D;
            rt_p0      <= rt_D;
            mdStart_p0 <= md_start_D;
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: cycle-by-cycle vector table for hazard_ctrl with a queue of expected outputs.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] rs_D, rt_D, a3_D;
   logic [1:0] tuse_rs_D, tuse_rt_D, tnew_D;
   logic       md_D, md_start_D, md_busy;
   logic       stall;
   logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;

   hazard_ctrl #(.REG_W(5), .TN_W(2)) dut (
      .clk(clk), .reset(reset),
      .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
      .a3_D(a3_D), .tnew_D(tnew_D), .md_D(md_D), .md_start_D(md_start_D),
      .md_busy(md_busy), .stall(stall),
      .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
      .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit rst, chk;
      int rs, rt, tus, tut, a3, tn;
      bit md, ms, busy;
      bit st;
      int frsD, frtD, frsE, frtE;
   } vec_t;

   typedef struct {
      int idx;
      bit st;
      int frsD, frtD, frsE, frtE;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic v(bit rst, bit chk, int rs, int rt, int tus, int tut,
                    int a3, int tn, bit md, bit ms, bit busy,
                    bit st, int frsD, int frtD, int frsE, int frtE);
      vec_t x;
      x.rst = rst; x.chk = chk; x.rs = rs; x.rt = rt; x.tus = tus; x.tut = tut;
      x.a3 = a3; x.tn = tn; x.md = md; x.ms = ms; x.busy = busy; x.st = st;
      x.frsD = frsD; x.frtD = frtD; x.frsE = frsE; x.frtE = frtE;
      vecs.push_back(x);
   endtask

   task automatic cmp(string name, int idx, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
      end
   endtask

   // Reset cycle with arbitrary nonzero D inputs, outputs not checked.
   task automatic rstRow();
      v(1,0, 5,6,0,0, 5,3, 1,1,1, 0,0,0,0,0);
   endtask

   initial begin
      exp_t e;
      reset = 1'b1; rs_D = '0; rt_D = '0; a3_D = '0; tuse_rs_D = '0; tuse_rt_D = '0;
      tnew_D = '0; md_D = 1'b0; md_start_D = 1'b0; md_busy = 1'b0;

      // reset for two cycles, then cleared state with unmatched sources
      rstRow(); rstRow();
      v(0,1, 7,3,0,0, 0,0, 0,0,0, 0,0,0,0,0);
      v(0,1, 0,0,3,3, 0,0, 0,0,0, 0,0,0,0,0);
      // lw $8 then beq rs=8 (tuse 0): stall with E tnew2, then M tnew1
      rstRow();
      v(0,1, 0,0,3,3, 8,2, 0,0,0, 0,0,0,0,0);
      v(0,1, 8,0,0,3, 0,0, 0,0,0, 1,0,0,0,0);
      v(0,1, 8,0,0,3, 0,0, 0,0,0, 1,0,0,0,0);
      v(0,1, 8,0,0,3, 0,0, 0,0,0, 0,0,0,0,0);
      // lw $8 then addu rs=8 (tuse 1): one stall, later forwarded from W in E
      rstRow();
      v(0,1, 0,0,3,3, 8,2, 0,0,0, 0,0,0,0,0);
      v(0,1, 8,0,1,3, 11,1, 0,0,0, 1,0,0,0,0);
      v(0,1, 8,0,1,3, 11,1, 0,0,0, 0,0,0,0,0);
      v(0,1, 0,0,3,3, 0,0, 0,0,0, 0,0,0,2,0);
      // addu $9 (tnew 1) then beq rs=9: one stall, then D forward from M
      rstRow();
      v(0,1, 0,0,3,3, 9,1, 0,0,0, 0,0,0,0,0);
      v(0,1, 9,0,0,0, 0,0, 0,0,0, 1,0,0,0,0);
      v(0,1, 9,0,0,0, 0,0, 0,0,0, 0,2,0,0,0);
      v(0,1, 0,0,3,3, 0,0, 0,0,0, 0,0,0,2,0);
      // lui $10 in E: D forward from E; then $10 in E and M: E wins; E-stage M beats W
      rstRow();
      v(0,1, 0,0,3,3, 10,0, 0,0,0, 0,0,0,0,0);
      v(0,1, 0,10,3,0, 10,0, 0,0,0, 0,0,1,0,0);
      v(0,1, 10,10,0,0, 0,0, 0,0,0, 0,1,1,0,1);
      v(0,1, 0,0,3,3, 0,0, 0,0,0, 0,0,0,1,1);
      // writes to $0 never stall or forward
      rstRow();
      v(0,1, 0,0,3,3, 0,3, 0,0,0, 0,0,0,0,0);
      v(0,1, 0,0,0,0, 0,0, 0,0,0, 0,0,0,0,0);
      v(0,1, 0,0,0,0, 0,0, 0,0,0, 0,0,0,0,0);
      // mult in E then mflo in D, MDU busy 5 cycles, reset while stalled
      rstRow();
      v(0,1, 0,0,3,3, 0,0, 1,1,0, 0,0,0,0,0);
      v(0,1, 0,0,3,3, 12,1, 1,0,0, 1,0,0,0,0);
      for (int i = 0; i < 5; i++) v(0,1, 0,0,3,3, 12,1, 1,0,1, 1,0,0,0,0);
      v(0,1, 0,0,3,3, 12,1, 1,0,0, 0,0,0,0,0);
      v(0,1, 0,0,3,3, 12,1, 1,0,1, 1,0,0,0,0);
      v(1,1, 0,0,3,3, 12,1, 1,0,1, 1,0,0,0,0);
      v(0,1, 0,0,3,3, 12,1, 1,0,1, 1,0,0,0,0);
      v(0,1, 0,0,3,3, 12,1, 1,0,0, 0,0,0,0,0);
      // reset during a load-use stall clears the hazard
      rstRow();
      v(0,1, 0,0,3,3, 8,2, 0,0,0, 0,0,0,0,0);
      v(1,1, 8,0,0,3, 0,0, 0,0,0, 1,0,0,0,0);
      v(0,1, 8,0,0,3, 0,0, 0,0,0, 0,0,0,0,0);

      foreach (vecs[i]) begin
         @(posedge clk);
         #1;
         reset      = vecs[i].rst;
         rs_D       = 5'(vecs[i].rs);
         rt_D       = 5'(vecs[i].rt);
         tuse_rs_D  = 2'(vecs[i].tus);
         tuse_rt_D  = 2'(vecs[i].tut);
         a3_D       = 5'(vecs[i].a3);
         tnew_D     = 2'(vecs[i].tn);
         md_D       = vecs[i].md;
         md_start_D = vecs[i].ms;
         md_busy    = vecs[i].busy;
         if (vecs[i].chk) begin
            e.idx = i; e.st = vecs[i].st;
            e.frsD = vecs[i].frsD; e.frtD = vecs[i].frtD;
            e.frsE = vecs[i].frsE; e.frtE = vecs[i].frtE;
            sb.push_back(e);
         end
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            cmp("stall",    e.idx, int'(stall),    int'(e.st));
            cmp("fwd_rs_D", e.idx, int'(fwd_rs_D), e.frsD);
            cmp("fwd_rt_D", e.idx, int'(fwd_rt_D), e.frtD);
            cmp("fwd_rs_E", e.idx, int'(fwd_rs_E), e.frsE);
            cmp("fwd_rt_E", e.idx, int'(fwd_rt_E), e.frtE);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
